// File: rtl/padding_scheduler.sv
// padding_scheduler: paces SIZE x SIZE pixel reads out of the feature RAM and
// forwards them as a valid-qualified stream to the padding stage, one frame at
// a time, waiting for the padded-frame end marker between frames.
// Optional feature macro: PAD_SCHED_STALL_EN (adds i_stall to pause issue).
module padding_scheduler #(
  parameter int N       = 8,
  parameter int CHANNEL = 3,
  parameter int SIZE    = 32,
  parameter int GAP     = 13,
  parameter int ADDR_W  = 16,
  parameter int FRAME_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [ADDR_W-1:0]    i_base_addr,
  input  logic [FRAME_W-1:0]   i_num_frames,
`ifdef PAD_SCHED_STALL_EN
  input  logic                 i_stall,
`endif
  output logic                 o_rd_en,
  output logic [ADDR_W-1:0]    o_rd_addr,
  input  logic [CHANNEL*N-1:0] i_rd_data,
  output logic                 o_pad_vld,
  output logic [CHANNEL*N-1:0] o_pad_din,
  input  logic                 i_pad_end,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [FRAME_W-1:0]   o_frame_idx
);

  localparam int PIX_W = $clog2(SIZE*SIZE+1);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP+1) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(SIZE*SIZE);
  localparam logic [GAP_W-1:0] GAP_LD   = GAP_W'(GAP);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  logic               r_rd_en;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [ADDR_W-1:0]  r_addr;      // next address to read; runs on across frames
  logic               r_pad_vld;
  logic               r_busy;
  logic               r_done;
  logic [FRAME_W-1:0] r_frame_idx;
  logic [FRAME_W-1:0] r_num;
  logic [PIX_W-1:0]   r_pix_cnt;   // pulses issued in the current frame
  logic [GAP_W-1:0]   r_gap_cnt;   // idle cycles left before the next pulse
  logic               r_seen_low;  // pad_end has dropped since this frame began
  logic               w_stall;

`ifdef PAD_SCHED_STALL_EN
  assign w_stall = i_stall;
`else
  assign w_stall = 1'b0;
`endif

  // The first read is issued on the same edge that accepts start, so rd_en
  // appears one cycle after start with no dead cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_addr      <= '0;
      r_pad_vld   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_idx <= '0;
      r_num       <= '0;
      r_pix_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_seen_low  <= 1'b0;
    end else begin
      r_rd_en    <= 1'b0;
      r_done     <= 1'b0;
      r_pad_vld  <= r_rd_en;
      r_seen_low <= r_seen_low | ~i_pad_end;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num       <= i_num_frames;
            r_frame_idx <= '0;
            r_busy      <= 1'b1;
            if (i_num_frames == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_ISSUE;
              r_rd_en    <= 1'b1;
              r_rd_addr  <= i_base_addr;
              r_addr     <= i_base_addr + ADDR_W'(1);
              r_pix_cnt  <= PIX_W'(1);
              r_gap_cnt  <= GAP_LD;
              r_seen_low <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          if (r_pix_cnt == PIX_LAST) begin
            r_state <= S_DRAIN;
          end else if (w_stall) begin
            r_gap_cnt <= r_gap_cnt;
          end else if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end else begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_addr;
            r_addr    <= r_addr + ADDR_W'(1);
            r_pix_cnt <= r_pix_cnt + PIX_W'(1);
            r_gap_cnt <= GAP_LD;
          end
        end
        S_DRAIN: begin
          // a stale high pad_end from the previous frame must not end this one
          if (r_seen_low && i_pad_end) begin
            if (r_frame_idx != r_num - FRAME_W'(1)) begin
              r_state     <= S_ISSUE;
              r_frame_idx <= r_frame_idx + FRAME_W'(1);
              r_pix_cnt   <= '0;
              r_gap_cnt   <= '0;
              r_seen_low  <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rd_en     = r_rd_en;
  assign o_rd_addr   = r_rd_addr;
  assign o_pad_vld   = r_pad_vld;
  assign o_pad_din   = i_rd_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_frame_idx = r_frame_idx;

endmodule

// File: tb/tb_padding_scheduler.sv
// Scoreboard bench for padding_scheduler (SIZE=4); expected read addresses,
// frame indices and pixel data are queued at start, a negedge monitor checks.
module tb_padding_scheduler;
  localparam int NPIX = 16;
`ifdef PAD_SCHED_STALL_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 2;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  num_frames = '0;
  logic        rd_en, pad_vld, busy, done, pad_end = 1'b1;
  logic [15:0] rd_addr;
  logic [23:0] rd_data = '0, pad_din;
  logic [7:0]  frame_idx;

  always #5 clk = ~clk;

  padding_scheduler #(.N(8), .CHANNEL(3), .SIZE(4), .GAP(GAP), .ADDR_W(16), .FRAME_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_num_frames(num_frames),
`ifdef PAD_SCHED_STALL_EN
    .i_stall(stall),
`endif
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_pad_vld(pad_vld),
    .o_pad_din(pad_din), .i_pad_end(pad_end), .o_busy(busy), .o_done(done),
    .o_frame_idx(frame_idx));

  // RAM model: RAM[a] = a, one-cycle read latency
  always @(posedge clk) if (rd_en) rd_data <= {8'h00, rd_addr};

  typedef struct {logic [15:0] addr; logic [7:0] fidx; int pidx;} exp_t;
  exp_t        rdq[$];
  logic [23:0] pdq[$];
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, rd_cnt = 0, last_rd = 0, extra = 0;
  int vcnt = 0, cd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // padding model: end marker drops on input, rises 5 cycles after 16th pixel
  initial forever begin
    @(posedge clk); #2;
    if (!rst_n) begin vcnt = 0; cd = 0; pad_end = 1'b1; end
    else if (pad_vld) begin
      pad_end = 1'b0; vcnt++;
      if (vcnt % NPIX == 0) cd = 5;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) pad_end = 1'b1;
    end
  end

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (done) done_cnt++;
    if (rd_en) begin
      rd_cnt++;
      if (rdq.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected actual_addr=%0h expected=no read", rd_addr);
      end else begin
        e = rdq.pop_front();
        chk("rd_addr", {16'h0, rd_addr}, {16'h0, e.addr});
        chk("frame_idx", {24'h0, frame_idx}, {24'h0, e.fidx});
        if (e.pidx % NPIX != 0) begin
          chk("rd_spacing", cyc - last_rd, GAP + 1 + extra);
          extra = 0;
        end
      end
      last_rd = cyc;
    end
    if (pad_vld) begin
      if (pdq.size() == 0) begin
        total++; bad++;
        $display("FAIL pad_unexpected actual=%0h expected=no pixel", pad_din);
      end else chk("pad_din", {8'h0, pad_din}, {8'h0, pdq.pop_front()});
    end
  end

  task automatic run(input logic [15:0] b, input logic [7:0] n);
    exp_t e;
    for (int f = 0; f < int'(n); f++)
      for (int p = 0; p < NPIX; p++) begin
        e.addr = 16'(int'(b) + f*NPIX + p); e.fidx = 8'(f); e.pidx = f*NPIX + p;
        rdq.push_back(e); pdq.push_back({8'h00, e.addr});
      end
    @(negedge clk); start = 1'b1; base_addr = b; num_frames = n;
    @(posedge clk); #1;
    chk("busy_k1", {31'h0, busy}, 1);
    chk("rd_en_k1", {31'h0, rd_en}, {31'h0, n != 0});
    chk("done_k1", {31'h0, done}, {31'h0, n == 0});
    @(negedge clk); start = 1'b0;
    if (n != 0) begin
      @(posedge clk); #1;
      chk("pad_vld_k2", {31'h0, pad_vld}, 1);
    end
  endtask

  task automatic wait_addr(input logic [15:0] a);
    int i;
    for (i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rd_en && rd_addr == a) break;
    end
    if (i == 1000) begin
      total++; bad++;
      $display("FAIL wait_addr_timeout actual=none expected=%0h", a);
    end
  endtask

  task automatic finish_run(input int d0);
    int i;
    for (i = 0; i < 2000 && !done; i++) @(negedge clk);
    if (i == 2000) begin
      total++; bad++;
      $display("FAIL done_timeout actual=0 expected=1");
    end
    @(posedge clk); #1;
    chk("busy_after_done", {31'h0, busy}, 0);
    chk("done_width", {31'h0, done}, 0);
    repeat (4) @(negedge clk);
    chk("done_count", done_cnt - d0, 1);
    chk("rd_left", rdq.size(), 0);
    chk("pad_left", pdq.size(), 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_rd_en", {31'h0, rd_en}, 0);
    chk("rst_rd_addr", {16'h0, rd_addr}, 0);
    chk("rst_pad_vld", {31'h0, pad_vld}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_frame_idx", {24'h0, frame_idx}, 0);
  endtask

  initial begin
    int d0, r0;
    repeat (3) @(posedge clk); #1;
    check_reset_vals();
    @(negedge clk); rst_n = 1'b1;

    // single frame
    d0 = done_cnt; run(16'h0100, 8'd1); finish_run(d0);

    // three frames; start re-pulsed in ISSUE and in DRAIN must be ignored
    d0 = done_cnt; run(16'h0100, 8'd3);
    wait_addr(16'h0104);
    @(negedge clk); start = 1'b1; base_addr = 16'h0500; num_frames = 8'd7;
    @(negedge clk); start = 1'b0;
    wait_addr(16'h010F);
    repeat (3) @(negedge clk);
    start = 1'b1; base_addr = 16'h0600; num_frames = 8'd9;
    @(negedge clk); start = 1'b0;
    finish_run(d0);

    // zero frames
    d0 = done_cnt; r0 = rd_cnt; run(16'h0700, 8'd0); finish_run(d0);
    chk("zero_frames_reads", rd_cnt - r0, 0);

    // reset mid-frame, then restart at a wrapping base address
    run(16'h0200, 8'd1);
    wait_addr(16'h0204);
    @(negedge clk); rst_n = 1'b0; #1;
    check_reset_vals();
    rdq.delete(); pdq.delete(); extra = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt; run(16'hFFF8, 8'd1); finish_run(d0);

`ifdef PAD_SCHED_STALL_EN
    // four stall cycles stretch exactly one pulse interval by four
    d0 = done_cnt; r0 = rd_cnt; run(16'h0400, 8'd1);
    wait_addr(16'h0405);
    #1; stall = 1'b1; extra = 4;
    repeat (4) @(posedge clk);
    #1; stall = 1'b0;
    finish_run(d0);
    chk("stall_pulse_count", rd_cnt - r0, NPIX);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
